// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, RV32 decode constants and issue-stage FSM states.
// Shared by the decoder, the issue stage and its interface users.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_INC = 4'd8;
  localparam logic [3:0] ALU_DEC = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction valid/ready handshake into the issue stage.
// master = instruction source, slave = alu_issue_stage.
interface alu_issue_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;

  modport master (
    output instr_valid,
    output instr_data,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    output instr_ready
  );

endinterface

// File: rtl/alu_instr_decoder.sv
// alu_instr_decoder: RV32 ALU-class word -> ALU opcode and fields.
// Anything outside the supported R/I subset is flagged illegal.
module alu_instr_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [3:0]      alu_op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            use_rs2,
  output logic            illegal
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       is_r;
  logic       is_i;
  logic       base;

  assign opc  = instr[6:0];
  assign f3   = instr[14:12];
  assign f7   = instr[31:25];
  assign rd   = instr[11:7];
  assign rs1  = instr[19:15];
  assign rs2  = instr[24:20];
  assign imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign is_r = (opc == OPC_OP);
  assign is_i = (opc == OPC_OPIMM);
  assign base = (f7 == F7_BASE);

  assign use_imm = is_i;
  assign use_rs2 = is_r;

  // Opcode select; f7 doubles as imm[11:5] for the shift-immediates.
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    unique case (1'b1)
      is_r: begin
        unique case (f3)
          F3_ADD: begin
            alu_op  = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            illegal = !(base || (f7 == F7_ALT));
          end
          F3_SLL: begin alu_op = ALU_SLL; illegal = !base; end
          F3_XOR: begin alu_op = ALU_XOR; illegal = !base; end
          F3_SRL: begin alu_op = ALU_SRL; illegal = !base; end
          F3_OR:  begin alu_op = ALU_OR;  illegal = !base; end
          F3_AND: begin alu_op = ALU_AND; illegal = !base; end
          default: illegal = 1'b1;
        endcase
      end
      is_i: begin
        unique case (f3)
          F3_ADD: alu_op = ALU_ADD;
          F3_SLL: begin alu_op = ALU_SLL; illegal = !base; end
          F3_XOR: alu_op = ALU_XOR;
          F3_SRL: begin alu_op = ALU_SRL; illegal = !base; end
          F3_OR:  alu_op = ALU_OR;
          F3_AND: alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue into a combinational ALU, regfile and writeback.
// ALU_FWD_EN: forward the EX result into ID instead of stalling one cycle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_if.slave      instr_if,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  output logic [3:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_zero,
  output logic            halted,
  output logic [31:0]     err_instr,
  input  logic            resume
);

  state_t          state;
  logic [XLEN-1:0] rf [NREGS];
  logic            ex_valid;
  logic [4:0]      ex_rd;

  logic [3:0]      id_op;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic            id_use_rs2;
  logic            id_illegal;

  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] op2_raw;
  logic [XLEN-1:0] op2;
  logic            hit1;
  logic            hit2;
  logic            stall;
  logic            accept;
  logic            issue;

  alu_instr_decoder #(.XLEN(XLEN)) u_dec (
    .instr   (instr_if.instr_data),
    .alu_op  (id_op),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .rd      (id_rd),
    .imm     (id_imm),
    .use_imm (id_use_imm),
    .use_rs2 (id_use_rs2),
    .illegal (id_illegal)
  );

  assign rd1 = (id_rs1 == 5'd0) ? '0 : rf[id_rs1];
  assign rd2 = (id_rs2 == 5'd0) ? '0 : rf[id_rs2];

  assign hit1 = ex_valid && (ex_rd != 5'd0) && (ex_rd == id_rs1)
              && !id_illegal;
  assign hit2 = ex_valid && (ex_rd != 5'd0) && (ex_rd == id_rs2)
              && id_use_rs2 && !id_illegal;

`ifdef ALU_FWD_EN
  assign stall = 1'b0;
  assign src1  = hit1 ? alu_result : rd1;
  assign src2  = hit2 ? alu_result : rd2;
`else
  assign stall = hit1 | hit2;
  assign src1  = rd1;
  assign src2  = rd2;
`endif

  assign op2_raw = id_use_imm ? id_imm : src2;
  assign op2     = is_shift(id_op)
                 ? {{(XLEN-5){1'b0}}, op2_raw[4:0]}
                 : op2_raw;

  assign instr_if.instr_ready = (state == ST_RUN) && !stall;
  assign accept = instr_if.instr_valid && instr_if.instr_ready;
  assign issue  = accept && !id_illegal;
  assign halted = (state == ST_HALT);

  // EX register, run/halt FSM and faulting-word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      err_instr    <= '0;
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_opcode   <= ALU_ADD;
    end else begin
      ex_valid <= issue;
      if (issue) begin
        ex_rd        <= id_rd;
        alu_operand1 <= src1;
        alu_operand2 <= op2;
        alu_opcode   <= id_op;
      end else begin
        ex_rd        <= '0;
        alu_operand1 <= '0;
        alu_operand2 <= '0;
        alu_opcode   <= ALU_ADD;
      end
      unique case (state)
        ST_RUN: begin
          if (accept && id_illegal) begin
            err_instr <= instr_if.instr_data;
            state     <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (resume) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Retire: regfile write and registered writeback record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_zero  <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd   <= ex_rd;
        wb_data <= alu_result;
        wb_zero <= alu_zero;
        if (ex_rd != 5'd0) rf[ex_rd] <= alu_result;
      end
    end
  end

endmodule
